// File: rtl/matrix_row_collector.sv
// matrix_row_collector: gathers NUM_BEATS beats of BEAT_LEN elements into one
// row-major ROWS x COLS matrix, then holds it until the consumer takes it.
// TRANSPOSE selects whether a beat carries a row (0) or a column (1).
module matrix_row_collector #(
    parameter int ROWS       = 2,
    parameter int COLS       = 2,
    parameter int DATA_WIDTH = 8,
    parameter int TRANSPOSE  = 0,
    localparam int BEAT_LEN  = (TRANSPOSE != 0) ? ROWS : COLS,
    localparam int NUM_BEATS = (TRANSPOSE != 0) ? COLS : ROWS,
    localparam int CNT_W     = $clog2(NUM_BEATS + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic [BEAT_LEN*DATA_WIDTH-1:0]     in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [ROWS*COLS*DATA_WIDTH-1:0]    out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [CNT_W-1:0]                   beat_count
);

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    state_t                            state, state_nxt;
    logic [CNT_W-1:0]                  count_nxt;
    logic [ROWS*COLS*DATA_WIDTH-1:0]   storage;
    logic                              last_beat;
    logic                              accept;

    // Handshake flags are pure decodes of the registered state, so out_ready
    // never reaches in_ready combinationally.
    assign in_ready  = (state == FILL);
    assign out_valid = (state == FULL);
    assign out_data  = storage;
    assign last_beat = (beat_count == CNT_W'(NUM_BEATS - 1));
    // clear wins over any beat arriving in the same cycle.
    assign accept    = in_valid && in_ready && !clear;

    // State and beat counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FILL;
            beat_count <= '0;
        end else begin
            state      <= state_nxt;
            beat_count <= count_nxt;
        end
    end

    // Next-state logic: clear dominates; FILL counts beats, FULL waits for the consumer.
    always_comb begin
        state_nxt = state;
        count_nxt = beat_count;
        if (clear) begin
            state_nxt = FILL;
            count_nxt = '0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        count_nxt = beat_count + CNT_W'(1);
                        if (last_beat) state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_nxt = FILL;
                        count_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = FILL;
                    count_nxt = '0;
                end
            endcase
        end
    end

    // Matrix storage: an accepted beat lands in row beat_count (or column
    // beat_count when transposed); untouched elements keep their old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            storage <= '0;
        end else if (accept) begin
            for (int j = 0; j < BEAT_LEN; j++) begin
                storage[((TRANSPOSE != 0) ? (j * COLS + int'(beat_count))
                                          : (int'(beat_count) * COLS + j)) * DATA_WIDTH +: DATA_WIDTH]
                    <= in_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule
